// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit core (flag indices, vectors, interrupt-entry states)
package cpu_pkg;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam logic [7:0] VEC_RESET = 8'h00;
    localparam logic [7:0] VEC_INTR = 8'h01;
    typedef enum logic [2:0] {IDLE, DRAIN, PUSH, VEC, LOAD} ie_state_t;
endpackage

// File: rtl/intr_edge_sync.sv
// intr_edge_sync: two-flop synchronizer plus rising-edge detector producing a one-cycle pulse
module intr_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);
    logic s1, s2, e;
    // Kept running through reset so a level already high at release is not seen as an edge
    always_ff @(posedge clk) begin
        s1 <= async_in;
        s2 <= s1;
        e  <= s2;
    end
    assign pulse = s2 & ~e & ~rst;
endmodule

// File: rtl/intr_entry_seq.sv
// intr_entry_seq: interrupt-entry sequencer that pushes the return PC, vectors, and restores flags on RTI
module intr_entry_seq
    import cpu_pkg::*;
#(
    parameter int DW = 8,
    parameter int FW = 4,
    parameter logic [DW-1:0] VEC_ADDR = DW'(VEC_INTR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          intr_in,
    input  logic [DW-1:0] pc_next,
    input  logic [FW-1:0] flags_in,
    input  logic [DW-1:0] sp_in,
    input  logic          boundary,
    input  logic          rti_commit,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_req,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          sp_we,
    output logic [DW-1:0] sp_wdata,
    output logic          pc_load,
    output logic [DW-1:0] pc_load_val,
    output logic          flags_restore,
    output logic [FW-1:0] flags_restore_val,
    output logic          in_service
);
    ie_state_t state;
    logic edge_p, pending;
    logic [DW-1:0] ret_pc, sp_q, vec_q;
    logic [FW-1:0] fshadow;
    intr_edge_sync u_sync (.clk(clk), .rst(rst), .async_in(intr_in), .pulse(edge_p));
    assign stall_req   = state != IDLE;
    assign mem_req     = state == PUSH || state == VEC;
    assign mem_we      = state == PUSH;
    assign mem_addr    = state == PUSH ? sp_q : state == VEC ? VEC_ADDR : '0;
    assign mem_wdata   = state == PUSH ? ret_pc : '0;
    assign pc_load     = state == LOAD;
    assign pc_load_val = state == LOAD ? vec_q : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pending           <= 1'b0;
            in_service        <= 1'b0;
            ret_pc            <= '0;
            sp_q              <= '0;
            vec_q             <= '0;
            fshadow           <= '0;
            sp_we             <= 1'b0;
            sp_wdata          <= '0;
            flags_restore     <= 1'b0;
            flags_restore_val <= '0;
        end else begin
            sp_we         <= 1'b0;
            flags_restore <= 1'b0;
            // An edge landing in LOAD belongs to the next service, so it survives the clear
            pending       <= edge_p | (pending & state != LOAD);
            if (state == LOAD)
                in_service <= 1'b1;
            else if (rti_commit && in_service) begin
                in_service        <= 1'b0;
                flags_restore     <= 1'b1;
                flags_restore_val <= fshadow;
            end
            case (state)
                IDLE:  if (pending && !in_service) state <= DRAIN;
                DRAIN: if (boundary) begin
                    ret_pc  <= pc_next;
                    fshadow <= flags_in;
                    sp_q    <= sp_in;
                    state   <= PUSH;
                end
                PUSH:  if (mem_ack) begin
                    sp_we    <= 1'b1;
                    sp_wdata <= sp_q - DW'(1);
                    state    <= VEC;
                end
                VEC:   if (mem_ack) begin
                    vec_q <= mem_rdata;
                    state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intr_entry_seq.sv
// tb_intr_entry_seq: scoreboard bench for the interrupt-entry sequencer
module tb_intr_entry_seq;
    logic       clk = 0, rst = 1, intr_in = 0, rti_commit = 0;
    logic [7:0] pc_next = 0, sp_in = 0, mem_rdata;
    logic [3:0] flags_in = 0;
    logic       boundary, mem_ack;
    logic       stall_req, mem_req, mem_we, sp_we, pc_load, flags_restore, in_service;
    logic [7:0] mem_addr, mem_wdata, sp_wdata, pc_load_val;
    logic [3:0] flags_restore_val;
    logic [7:0] mem [256];
    int         b_wait = 0, a_wait = 0, drain_cnt = 0, ack_cnt = 0;
    int         stall_cnt = 0, pl_cnt = 0, fr_cnt = 0, tests = 0, fails = 0;
    logic [15:0] wq[$];
    logic [7:0]  spq[$], pcq[$];
    logic [3:0]  flq[$];
    logic        p_req = 0, p_ack = 0;
    logic [16:0] p_bus = 0;

    intr_entry_seq dut (
        .clk(clk), .rst(rst), .intr_in(intr_in), .pc_next(pc_next), .flags_in(flags_in),
        .sp_in(sp_in), .boundary(boundary), .rti_commit(rti_commit), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stall_req(stall_req), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .sp_we(sp_we), .sp_wdata(sp_wdata),
        .pc_load(pc_load), .pc_load_val(pc_load_val), .flags_restore(flags_restore),
        .flags_restore_val(flags_restore_val), .in_service(in_service)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && ack_cnt >= a_wait;
    assign boundary  = drain_cnt >= b_wait;

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
        ack_cnt   <= (mem_req && !mem_ack) ? ack_cnt + 1 : 0;
        drain_cnt <= (stall_req && !mem_req && !pc_load && !boundary) ? drain_cnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (stall_req) stall_cnt++;
        if (pc_load) pl_cnt++;
        if (flags_restore) fr_cnt++;
        if (p_req && !p_ack && mem_req) check("mem_stable", {mem_we, mem_addr, mem_wdata}, p_bus);
        p_req = mem_req;
        p_ack = mem_ack;
        p_bus = {mem_we, mem_addr, mem_wdata};
        if (mem_req && mem_ack && mem_we) begin
            if (wq.size() == 0) check("write_q", 0, 1);
            else check("push_write", {mem_addr, mem_wdata}, wq.pop_front());
        end
        if (sp_we) begin
            if (spq.size() == 0) check("sp_q", 0, 1);
            else check("sp_wdata", sp_wdata, spq.pop_front());
        end
        if (pc_load) begin
            if (pcq.size() == 0) check("pc_q", 0, 1);
            else check("pc_load_val", pc_load_val, pcq.pop_front());
        end
        if (flags_restore) begin
            if (flq.size() == 0) check("flag_q", 0, 1);
            else check("flags_val", flags_restore_val, flq.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setup(input logic [7:0] pc, input logic [7:0] sp, input logic [3:0] fl,
                         input logic [7:0] vec, input int bw, input int aw);
        pc_next = pc;
        sp_in = sp;
        flags_in = fl;
        mem[1] = vec;
        b_wait = bw;
        a_wait = aw;
        wq.push_back({sp, pc});
        spq.push_back(sp - 8'd1);
        pcq.push_back(vec);
        stall_cnt = 0;
        pl_cnt = 0;
    endtask

    task automatic wait_service(input string tag, input int stalls);
        for (int i = 0; i < 80 && !in_service; i++) tick(1);
        check({tag, "_in_service"}, in_service, 1);
        check({tag, "_stall_cycles"}, stall_cnt, stalls);
        check({tag, "_pc_loads"}, pl_cnt, 1);
    endtask

    task automatic do_rti(input logic [3:0] fl);
        flq.push_back(fl);
        fr_cnt = 0;
        rti_commit = 1;
        tick(1);
        rti_commit = 0;
        tick(2);
        check("rti_in_service", in_service, 0);
        check("rti_pulses", fr_cnt, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        tick(5);
        check("rst_stall", stall_req, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_pc_load", pc_load, 0);
        check("rst_in_service", in_service, 0);
        rst = 0;
        tick(2);
        check("idle_outputs", {stall_req, mem_req, sp_we, pc_load, flags_restore, in_service}, 0);
        // Basic entry and RTI
        setup(8'h37, 8'hFF, 4'b1010, 8'h80, 0, 0);
        intr_in = 1;
        wait_service("basic", 4);
        check("basic_mem_ff", mem[8'hFF], 8'h37);
        intr_in = 0;
        tick(4);
        fr_cnt = 0;
        do_rti(4'b1010);
        // RTI while idle is ignored
        fr_cnt = 0;
        rti_commit = 1;
        tick(1);
        rti_commit = 0;
        tick(2);
        check("rti_idle_ignored", fr_cnt, 0);
        // SP wrap-around
        setup(8'h52, 8'h00, 4'b0101, 8'h9C, 0, 0);
        intr_in = 1;
        wait_service("wrap", 4);
        check("wrap_mem_00", mem[8'h00], 8'h52);
        intr_in = 0;
        tick(4);
        do_rti(4'b0101);
        // Wait states in drain, push and vector fetch
        setup(8'hA4, 8'h80, 4'b0011, 8'h44, 3, 2);
        intr_in = 1;
        wait_service("wait", 11);
        intr_in = 0;
        tick(4);
        // Nested edge is held until RTI, then entry starts right after
        setup(8'h10, 8'h7F, 4'b1100, 8'h22, 0, 0);
        intr_in = 1;
        tick(10);
        check("nest_blocked", stall_cnt, 0);
        flq.push_back(4'b0011);
        rti_commit = 1;
        tick(1);
        rti_commit = 0;
        tick(1);
        check("nest_entry_starts", stall_req, 1);
        wait_service("nest", 4);
        intr_in = 0;
        tick(4);
        do_rti(4'b1100);
        // Reset in VEC aborts the sequence
        pc_next = 8'h61;
        sp_in = 8'h40;
        a_wait = 3;
        b_wait = 0;
        wq.push_back({8'h40, 8'h61});
        spq.push_back(8'h3F);
        pl_cnt = 0;
        intr_in = 1;
        for (int i = 0; i < 30 && !(mem_req && !mem_we); i++) tick(1);
        check("reach_vec", mem_req && !mem_we, 1);
        rst = 1;
        tick(1);
        check("abort_outputs", {stall_req, mem_req, mem_we, mem_addr, mem_wdata, sp_we, pc_load,
                                pc_load_val, flags_restore, in_service}, 0);
        tick(4);
        rst = 0;
        stall_cnt = 0;
        tick(15);
        check("abort_no_pc_load", pl_cnt, 0);
        check("level_no_entry", stall_cnt, 0);
        check("abort_mem_40", mem[8'h40], 8'h61);
        check("queues_drained", wq.size() + spq.size() + pcq.size() + flq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
